acc_sequencer: RTL and testbench
================================

// Module: acc_sequencer
// PURPOSE
//  Control FSM for one FP multiply-accumulate lane (bias-preload accumulator, combinational FP adder).
//  Per output neuron it:
//   - preloads the bias;
//   - issues N_TERMS weight/input fetches;
//   - drives acc_enable so it lines up with products arriving PIPE_LAT cycles after issue;
//   - presents the finished sum with a valid/ready handshake.
//  It loops over N_OUTPUTS neurons per start pulse. Used by the LeNet5 conv/FC layer wrappers.
// PARAMETERS
//  N_TERMS    25  products summed per neuron (kernel size / fan-in), >=1
//  N_OUTPUTS   6  neurons processed per start, >=1
//  PIPE_LAT    3  cycles from issue_valid to product at accumulator Data_in, >=1
//  TERM_W      5  width of term_idx, 2^TERM_W >= N_TERMS
//  OUT_W       3  width of out_index/bias_addr, 2^OUT_W >= N_OUTPUTS
//  WADDR_W     8  width of weight_addr, 2^WADDR_W >= N_TERMS*N_OUTPUTS
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  reset        in   1        synchronous, active-high
//  start        in   1        begin a run; sampled in IDLE only
//  pause        in   1        suppress issue this cycle (upstream input not ready)
//  issue_valid  out  1        term fetch issued this cycle
//  term_idx     out  TERM_W   input-window index k of the issued term
//  weight_addr  out  WADDR_W  weight address = n*N_TERMS + k (running counter, no multiplier)
//  bias_addr    out  OUT_W    bias address = current neuron n
//  acc_enable   out  1        accumulator Enable
//  acc_bias_sel out  1        accumulator bias_sel; 0 selects bias one cycle later (acc registers it)
//  out_valid    out  1        accumulator Data_out holds the final sum of neuron out_index
//  out_index    out  OUT_W    neuron index of the presented result
//  out_ready    in   1        consumer accepts the result
//  busy         out  1        high in every state except IDLE
//  done         out  1        one-cycle pulse after the last neuron is accepted
// BEHAVIOUR
//  Reset (synchronous, any state):
//   - state=IDLE; n=k=weight_addr=0; delay line cleared.
//   - Outputs 0, except acc_bias_sel=1.
//   - Reset mid-run abandons the run; no done pulse.
//  States:
//   IDLE  - start=1 -> PRE with n=0, weight_addr=0.
//   PRE   - 1 cycle; acc_bias_sel=0; bias_addr=n -> LOAD.
//   LOAD  - 1 cycle; acc_enable=1 (acc loads bias); acc_bias_sel=1 from here on -> ISSUE with k=0.
//   ISSUE - if pause=0: issue_valid=1, term_idx=k, weight_addr presented, then k++ and weight_addr++.
//         - if pause=1: issue_valid=0, k and weight_addr hold.
//         - after issuing k=N_TERMS-1 -> DRAIN.
//   DRAIN - wait until the delay line is empty and the last acc_enable has fired -> OUT.
//   OUT   - out_valid=1, out_index=n, held stable until out_ready=1.
//         - on handshake: if n==N_OUTPUTS-1 -> DONE; else n++ -> PRE (weight_addr continues).
//   DONE  - done=1 for one cycle -> IDLE.
//  Alignment:
//   - PIPE_LAT-deep shift register of issue_valid.
//   - acc_enable (outside LOAD) = delay-line output, so each product is added exactly once.
//   - Paused cycles produce no enable.
//  out_valid timing: rises the cycle after the last add enable, so Data_out is already updated.
//  Per-neuron latency with no pause and out_ready=1: 2 + N_TERMS + PIPE_LAT + 1 cycles.
//  start outside IDLE is ignored. pause outside ISSUE has no effect.
//  The delay line shifts every cycle regardless of pause.
//  acc_enable never coincides with bias preload, since LOAD precedes all issues of the neuron.
// TESTING
//  1 N_TERMS=3, N_OUTPUTS=1, PIPE_LAT=2, out_ready=1, start pulse:
//    PRE@t1, LOAD@t2, issue t3..t5, acc_enable t2 and t5..t7, out_valid@t8, done@t9.
//  2 Default params, bias=1.0, all products 1.0:
//    each neuron's Data_out=26.0 at out_valid; out_index runs 0..5; weight_addr reaches 149.
//  3 pause high at k=1 and k=2 for 3 cycles each:
//    k not skipped or repeated; exactly 25 acc_enable after LOAD; sum unchanged vs test 2.
//  4 out_ready low for 5 cycles in OUT:
//    out_valid and out_index held; no acc_enable; next PRE only after handshake.
//  5 reset asserted mid-ISSUE:
//    next cycle IDLE, all outputs 0, acc_bias_sel=1; new start runs clean from n=0.
//  6 start pulsed during ISSUE and during DONE:
//    ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/acc_sequencer_if.sv
// Term-fetch, accumulator-control and result-handshake bundle between the
// MAC lane sequencer (master) and the datapath/consumer (slave).
interface acc_sequencer_if #(
    parameter int TERM_W  = 5,
    parameter int OUT_W   = 3,
    parameter int WADDR_W = 8
);
    logic               issue_valid;
    logic [TERM_W-1:0]  term_idx;
    logic [WADDR_W-1:0] weight_addr;
    logic [OUT_W-1:0]   bias_addr;
    logic               acc_enable;
    logic               acc_bias_sel;
    logic               out_valid;
    logic [OUT_W-1:0]   out_index;
    logic               out_ready;

    modport master (
        output issue_valid, term_idx, weight_addr, bias_addr,
        output acc_enable, acc_bias_sel, out_valid, out_index,
        input  out_ready
    );

    modport slave (
        input  issue_valid, term_idx, weight_addr, bias_addr,
        input  acc_enable, acc_bias_sel, out_valid, out_index,
        output out_ready
    );
endinterface

// File: rtl/acc_sequencer.sv
// Control FSM for one FP multiply-accumulate lane: bias preload, term issue,
// product-aligned accumulate enables and per-neuron result handshake.
module acc_sequencer #(
    parameter int N_TERMS   = 25,
    parameter int N_OUTPUTS = 6,
    parameter int PIPE_LAT  = 3,
    parameter int TERM_W    = 5,
    parameter int OUT_W     = 3,
    parameter int WADDR_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            pause,
    acc_sequencer_if.master bus,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [TERM_W-1:0]   K_LAST   = TERM_W'(N_TERMS - 1);
    localparam logic [OUT_W-1:0]    N_LAST   = OUT_W'(N_OUTPUTS - 1);
    localparam logic [PIPE_LAT-1:0] DLY_TAIL = PIPE_LAT'(1) << (PIPE_LAT - 1);

    state_t               state;
    state_t               state_nxt;
    logic [OUT_W-1:0]     n;
    logic [TERM_W-1:0]    k;
    logic [WADDR_W-1:0]   waddr;
    logic [PIPE_LAT-1:0]  issue_dly;
    logic                 issue_fire;
    logic                 older_pending;

    assign issue_fire    = (state == S_ISSUE) && !pause;
    // Anything still in flight behind the tail stage means more adds are coming.
    assign older_pending = |(issue_dly & ~DLY_TAIL);

    assign bus.term_idx    = k;
    assign bus.weight_addr = waddr;
    assign bus.bias_addr   = n;
    assign bus.out_index   = n;
    assign bus.acc_enable  = (state == S_LOAD) || issue_dly[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        bus.issue_valid  = 1'b0;
        bus.acc_bias_sel = 1'b1;
        bus.out_valid    = 1'b0;
        busy             = (state != S_IDLE);
        done             = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_PRE;
            end
            S_PRE: begin
                bus.acc_bias_sel = 1'b0;
                state_nxt        = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                bus.issue_valid = issue_fire;
                if (issue_fire && (k == K_LAST)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // The tail stage fires this cycle if it holds the last term.
                if (!older_pending) state_nxt = S_OUT;
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = (n == N_LAST) ? S_DONE : S_PRE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n         <= '0;
            k         <= '0;
            waddr     <= '0;
            issue_dly <= '0;
        end else begin
            issue_dly <= (issue_dly << 1) | PIPE_LAT'(issue_fire);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n     <= '0;
                        waddr <= '0;
                    end
                end
                S_LOAD: begin
                    k <= '0;
                end
                S_ISSUE: begin
                    if (issue_fire) begin
                        waddr <= waddr + WADDR_W'(1);
                        k     <= (k == K_LAST) ? '0 : k + TERM_W'(1);
                    end
                end
                S_OUT: begin
                    // weight_addr keeps running across neurons: n*N_TERMS + k.
                    if (bus.out_ready && (n != N_LAST)) n <= n + OUT_W'(1);
                end
                S_DONE: begin
                    n     <= '0;
                    k     <= '0;
                    waddr <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: a small-parameter lane for exact cycle
// timing plus a default lane driving a behavioural accumulator.
module tb_acc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_s = 1'b0, pause_s = 1'b0, busy_s, done_s;
    logic start_d = 1'b0, pause_d = 1'b0, busy_d, done_d;

    acc_sequencer_if #(.TERM_W(2), .OUT_W(1), .WADDR_W(2)) if_s ();
    acc_sequencer_if #(.TERM_W(5), .OUT_W(3), .WADDR_W(8)) if_d ();

    acc_sequencer #(
        .N_TERMS(3), .N_OUTPUTS(1), .PIPE_LAT(2),
        .TERM_W(2), .OUT_W(1), .WADDR_W(2)
    ) dut_s (
        .clk(clk), .reset(rst), .start(start_s), .pause(pause_s),
        .bus(if_s), .busy(busy_s), .done(done_s)
    );

    acc_sequencer #(
        .N_TERMS(25), .N_OUTPUTS(6), .PIPE_LAT(3),
        .TERM_W(5), .OUT_W(3), .WADDR_W(8)
    ) dut_d (
        .clk(clk), .reset(rst), .start(start_d), .pause(pause_d),
        .bus(if_d), .busy(busy_d), .done(done_d)
    );

    // Accumulator model: bias = 100 + bias_addr, product = issued weight_addr,
    // arriving three cycles after issue.
    logic [7:0] pp0 = 8'd0, pp1 = 8'd0, pp2 = 8'd0;
    logic       sel_q = 1'b1;
    logic [2:0] baddr_q = 3'd0;
    int acc_val = 0;
    int adds = 0;
    int max_wa = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        pp0     <= if_d.issue_valid ? if_d.weight_addr : 8'd0;
        pp1     <= pp0;
        pp2     <= pp1;
        sel_q   <= if_d.acc_bias_sel;
        baddr_q <= if_d.bias_addr;
        if (if_d.acc_enable) begin
            if (sel_q) begin
                acc_val <= acc_val + int'(pp2);
                adds    <= adds + 1;
            end else begin
                acc_val <= 100 + int'(baddr_q);
                adds    <= 0;
            end
        end
        if (if_d.issue_valid && (int'(if_d.weight_addr) > max_wa)) max_wa <= int'(if_d.weight_addr);
        if (done_d) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(input int bound, output int cycles);
        cycles = 0;
        while (!if_d.out_valid && cycles < bound) begin
            tick();
            cycles++;
        end
    endtask

    task automatic finish_run();
        int c;
        c = 0;
        while (busy_d && c < 500) begin
            tick();
            c++;
        end
        check("run_end_idle", busy_d, 0);
    endtask

    logic [10:0] iv_tr, en_tr, ov_tr, dn_tr, bz_tr, bs_tr;
    logic [5:0]  ti_tr, wa_tr;
    int c;
    int dc0;

    initial begin
        if_s.out_ready = 1'b1;
        if_d.out_ready = 1'b1;
        tick();
        tick();
        check("reset_flags_d", {busy_d, done_d, if_d.issue_valid, if_d.acc_enable,
                                if_d.out_valid, if_d.acc_bias_sel}, 6'b000001);
        check("reset_flags_s", {busy_s, done_s, if_s.issue_valid, if_s.acc_enable,
                                if_s.out_valid, if_s.acc_bias_sel}, 6'b000001);
        rst = 1'b0;
        tick();

        // Test 1: cycle-exact trace on the small lane.
        iv_tr = '0; en_tr = '0; ov_tr = '0; dn_tr = '0; bz_tr = '0; bs_tr = '0;
        ti_tr = '0; wa_tr = '0;
        start_s = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1) start_s = 1'b0;
            iv_tr[t] = if_s.issue_valid;
            en_tr[t] = if_s.acc_enable;
            ov_tr[t] = if_s.out_valid;
            dn_tr[t] = done_s;
            bz_tr[t] = busy_s;
            bs_tr[t] = if_s.acc_bias_sel;
            if (if_s.issue_valid) begin
                ti_tr = {ti_tr[3:0], if_s.term_idx};
                wa_tr = {wa_tr[3:0], if_s.weight_addr};
            end
            if (t == 8) check("t1_out_index", if_s.out_index, 0);
        end
        check("t1_issue_trace", iv_tr, 11'h038);
        check("t1_enable_trace", en_tr, 11'h0E4);
        check("t1_valid_trace", ov_tr, 11'h100);
        check("t1_done_trace", dn_tr, 11'h200);
        check("t1_busy_trace", bz_tr, 11'h3FE);
        check("t1_bias_sel_trace", bs_tr, 11'h7FC);
        check("t1_term_idx_seq", ti_tr, 6'h06);
        check("t1_weight_addr_seq", wa_tr, 6'h06);

        // Test 2: full default run, out_ready held high.
        dc0 = done_cnt;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (n > 0) tick();
            wait_ov(40, c);
            check($sformatf("t2_latency_n%0d", n), c + 1, 31);
            check($sformatf("t2_out_index_n%0d", n), if_d.out_index, n);
            check($sformatf("t2_sum_n%0d", n), acc_val, 400 + 626 * n);
            check($sformatf("t2_adds_n%0d", n), adds, 25);
        end
        tick();
        check("t2_done_pulse", done_d, 1);
        tick();
        check("t2_idle_after", {busy_d, done_d}, 2'b00);
        check("t2_max_weight_addr", max_wa, 149);
        check("t2_done_count", done_cnt - dc0, 1);

        // Test 3: pause outside ISSUE, then 3-cycle pauses at k=1 and k=2.
        start_d = 1'b1;
        pause_d = 1'b1;
        tick();
        start_d = 1'b0;
        tick();
        pause_d = 1'b0;
        tick();
        check("t3_issue_k0", {if_d.issue_valid, if_d.term_idx}, 6'd32);
        tick();
        pause_d = 1'b1;
        #1;
        check("t3_paused_k1", {if_d.issue_valid, if_d.term_idx}, 6'd1);
        tick();
        tick();
        tick();
        pause_d = 1'b0;
        #1;
        check("t3_issue_k1", {if_d.issue_valid, if_d.term_idx}, 6'd33);
        tick();
        pause_d = 1'b1;
        tick();
        tick();
        tick();
        pause_d = 1'b0;
        #1;
        check("t3_issue_k2", {if_d.issue_valid, if_d.term_idx}, 6'd34);
        wait_ov(40, c);
        check("t3_latency", c, 26);
        check("t3_sum", acc_val, 400);
        check("t3_adds", adds, 25);
        finish_run();

        // Test 4: consumer stalls for 5 cycles in OUT.
        if_d.out_ready = 1'b0;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        wait_ov(40, c);
        check("t4_latency", c, 30);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_hold_%0d", i), {if_d.out_valid, if_d.out_index,
                                                if_d.acc_enable, if_d.acc_bias_sel}, 6'b100001);
        end
        check("t4_sum_held", acc_val, 400);
        if_d.out_ready = 1'b1;
        tick();
        check("t4_pre_after_hs", {if_d.out_valid, if_d.acc_bias_sel, if_d.bias_addr}, 5'b00001);

        // Test 5: reset in the middle of ISSUE for neuron 1.
        tick();
        tick();
        tick();
        tick();
        check("t5_mid_issue_addr", {if_d.term_idx, if_d.weight_addr}, {5'd2, 8'd27});
        dc0 = done_cnt;
        rst = 1'b1;
        tick();
        check("t5_reset_flags", {busy_d, done_d, if_d.issue_valid, if_d.acc_enable,
                                 if_d.out_valid, if_d.acc_bias_sel}, 6'b000001);
        check("t5_reset_fields", {if_d.term_idx, if_d.weight_addr, if_d.bias_addr,
                                  if_d.out_index}, 0);
        rst = 1'b0;
        tick();
        check("t5_idle_after", busy_d, 0);

        // Test 6: stray start pulses during ISSUE and DONE are ignored.
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        wait_ov(40, c);
        check("t6_latency_n0", c, 30);
        check("t6_out_index_n0", if_d.out_index, 0);
        check("t6_sum_n0", acc_val, 400);
        tick();
        tick();
        tick();
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        wait_ov(40, c);
        check("t6_latency_n1", c, 27);
        check("t6_out_index_n1", if_d.out_index, 1);
        check("t6_sum_n1", acc_val, 1026);
        c = 0;
        while (!done_d && c < 300) begin
            tick();
            c++;
        end
        check("t6_done_seen", done_d, 1);
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        check("t6_idle_after_done", busy_d, 0);
        tick();
        check("t6_no_restart", busy_d, 0);
        check("t6_done_count", done_cnt - dc0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
